// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, LSB first, one bit per clock.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               busy_d, done_d;
    logic [WIDTH-1:0]   a_sh_q, b_sh_q, d_sh_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               br_q;
    logic               accept, last_bit;
    logic               a0, b0, d_bit, br_next;
    logic [WIDTH-1:0]   d_sh_next;

    assign accept   = (state_q == S_IDLE) && start;
    assign last_bit = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // Full-subtractor cell on the current LSBs
    assign a0        = a_sh_q[0];
    assign b0        = b_sh_q[0];
    assign d_bit     = a0 ^ b0 ^ br_q;
    assign br_next   = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    assign d_sh_next = {d_bit, d_sh_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)    state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:                state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Flag decode from the next state so busy/done come straight from flops
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic a_msb_q, b_msb_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            d_sh_q     <= '0;
            cnt_q      <= '0;
            br_q       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else if (accept) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            d_sh_q  <= '0;
            br_q    <= borrow_in;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
        end else if (state_q == S_RUN) begin
            a_sh_q <= a_sh_q >> 1;
            b_sh_q <= b_sh_q >> 1;
            d_sh_q <= d_sh_next;
            br_q   <= br_next;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                diff       <= d_sh_next;
                borrow_out <= br_next;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                ovf        <= (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         borrow_in;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
    logic         ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

`ifndef SERIAL_SUB_SIGNED_OVF_EN
    assign ovf = 1'b0;
`endif

    // Reference: plain unsigned arithmetic with one extra bit for the borrow
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic bi);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [W-1:0] d);
        return (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
    endfunction

    // Issue one operation and observe the result; operands are scrambled after acceptance
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbi,
                          output logic [W-1:0] od, output logic obo, output logic oov,
                          output int busy_cycles, output bit done_seen, output int done_len);
        @(negedge clk);
        a = xa; b = xb; borrow_in = xbi; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        busy_cycles = 0; done_seen = 1'b0; done_len = 0;
        od = '0; obo = 1'b0; oov = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            @(negedge clk);
            if (done) begin
                done_seen = 1'b1;
                od = diff; obo = borrow_out; oov = ovf;
            end else if (busy) begin
                busy_cycles++;
            end
        end
        if (done_seen) begin
            @(negedge clk);
            done_len = done ? 2 : 1;
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                            input logic xbi, input bit chk_timing);
        logic [W-1:0] d;
        logic         bo, ov;
        int           bc, dl;
        bit           ds;
        logic [W:0]   r;
        r = ref_sub(xa, xb, xbi);
        run_op(xa, xb, xbi, d, bo, ov, bc, ds, dl);
        checks++;
        if (!ds) begin
            failures++;
            $display("FAIL %s timeout: done never seen, required done within 40 cycles", name);
            return;
        end
        checks++;
        if (d !== r[W-1:0]) begin
            failures++;
            $display("FAIL %s diff: got %h required %h", name, d, r[W-1:0]);
        end
        checks++;
        if (bo !== r[W]) begin
            failures++;
            $display("FAIL %s borrow_out: got %b required %b", name, bo, r[W]);
        end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        checks++;
        if (ov !== ref_ovf(xa, xb, r[W-1:0])) begin
            failures++;
            $display("FAIL %s ovf: got %b required %b", name, ov, ref_ovf(xa, xb, r[W-1:0]));
        end
`endif
        if (chk_timing) begin
            checks++;
            if (bc != W) begin
                failures++;
                $display("FAIL %s busy_cycles: got %0d required %0d", name, bc, W);
            end
            checks++;
            if (dl != 1) begin
                failures++;
                $display("FAIL %s done_len: got %0d required 1", name, dl);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, diff, borrow_out, ovf} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bo=%b ovf=%b required all 0",
                     busy, done, diff, borrow_out, ovf);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, diff, borrow_out} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b done=%b diff=%h bo=%b required all 0",
                     busy, done, diff, borrow_out);
        end
    endtask

    task automatic test_directed();
        check_op("dir_05_03", 8'h05, 8'h03, 1'b0, 1'b1);
        check_op("dir_03_05", 8'h03, 8'h05, 1'b0, 1'b1);
        check_op("dir_00_00_b1", 8'h00, 8'h00, 1'b1, 1'b1);
        check_op("dir_ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b1);
        check_op("dir_80_01", 8'h80, 8'h01, 1'b0, 1'b1);
        check_op("dir_7f_ff", 8'h7F, 8'hFF, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            check_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    endtask

    // Start pulses in RUN cycles 3 and 5 and in DONE must be ignored
    task automatic test_ignore_start();
        logic [W-1:0] xa, xb, d;
        logic [W:0]   r;
        logic         bo;
        bit           ds;
        int           extra;
        xa = 8'hC4; xb = 8'h39;
        r = ref_sub(xa, xb, 1'b1);
        @(negedge clk);
        a = xa; b = xb; borrow_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ds = 1'b0; d = '0; bo = 1'b0;
        for (int i = 1; i <= 20 && !ds; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 5) ? 1'b1 : 1'b0;
            a = 8'h11; b = 8'h99; borrow_in = 1'b0;
            if (done) begin
                ds = 1'b1; d = diff; bo = borrow_out;
                start = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        checks++;
        if (!ds || d !== r[W-1:0] || bo !== r[W]) begin
            failures++;
            $display("FAIL ignore_start_result: got seen=%b diff=%h bo=%b required diff=%h bo=%b",
                     ds, d, bo, r[W-1:0], r[W]);
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL ignore_start_no_new_op: got %0d busy/done cycles required 0", extra);
        end
    endtask

    // start held high: one result per W+2 cycles, outputs stable in between
    task automatic test_back_to_back();
        logic [W-1:0] xa, xb;
        logic         xbi;
        logic [W:0]   r, prev;
        int           last_done, n_done, bad_period, bad_val, bad_stable;
        xa = W'($urandom); xb = W'($urandom); xbi = 1'($urandom);
        r = ref_sub(xa, xb, xbi);
        prev = '0; last_done = -1; n_done = 0; bad_period = 0; bad_val = 0; bad_stable = 0;
        @(negedge clk);
        a = xa; b = xb; borrow_in = xbi; start = 1'b1;
        for (int t = 0; t < 60 && n_done < 4; t++) begin
            @(negedge clk);
            if (done) begin
                if ({borrow_out, diff} !== r) bad_val++;
                if (last_done >= 0 && (t - last_done) != int'(W + 2)) bad_period++;
                last_done = t;
                n_done++;
                prev = r;
                xa = W'($urandom); xb = W'($urandom); xbi = 1'($urandom);
                r = ref_sub(xa, xb, xbi);
                a = xa; b = xb; borrow_in = xbi;
            end else if (n_done > 0 && {borrow_out, diff} !== prev) begin
                bad_stable++;
            end
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);
        checks++;
        if (n_done != 4) begin
            failures++;
            $display("FAIL b2b_count: got %0d done pulses required 4", n_done);
        end
        checks++;
        if (bad_period != 0) begin
            failures++;
            $display("FAIL b2b_period: got %0d bad intervals required 0 (period %0d)",
                     bad_period, W + 2);
        end
        checks++;
        if (bad_val != 0) begin
            failures++;
            $display("FAIL b2b_value: got %0d wrong results required 0", bad_val);
        end
        checks++;
        if (bad_stable != 0) begin
            failures++;
            $display("FAIL b2b_stable: got %0d unstable samples required 0", bad_stable);
        end
    endtask

    task automatic test_async_reset();
        int stray;
        check_op("pre_reset", 8'h9A, 8'h21, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'h40; b = 8'h0F; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, borrow_out, ovf} !== '0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b done=%b diff=%h bo=%b ovf=%b required all 0",
                     busy, done, diff, borrow_out, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done || busy || diff !== '0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL async_reset_no_done: got %0d active/nonzero samples required 0", stray);
        end
        check_op("post_reset", 8'h40, 8'h0F, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
